// File: rtl/uart_pkg.sv
// Shared UART types: feeder FSM states and the byte width shared with uart_t/uart_r.
package uart_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    REQ  = 2'd2,
    WAIT = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; head is visible on rd_data whenever not empty.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              do_wr, do_rd;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus newd/donetx handshake sequencer feeding the UART transmitter.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    newd,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    donetx,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy,
  output logic                    err_to
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  feeder_state_t     state_q, state_d;
  logic              donetx_q;
  logic              newd_q, newd_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_to_q, err_to_d;
  logic              pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] head;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign in_ready = !fifo_full;
  assign newd     = newd_q;
  assign tx_data  = tx_data_q;
  assign err_to   = err_to_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    state_d   = state_q;
    newd_d    = newd_q;
    tx_data_d = tx_data_q;
    cnt_d     = '0;
    err_to_d  = err_to_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          tx_data_d = head;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        newd_d  = 1'b1;
        state_d = REQ;
      end
      REQ: begin
        // The request is never withdrawn; a slow ack only flags err_to.
        if (!donetx_q) begin
          newd_d  = 1'b0;
          state_d = WAIT;
        end else if (cnt_q == CNT_LAST) begin
          err_to_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT: begin
        if (donetx_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // donetx_q resets high: the transmitter reads as idle until its first frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      donetx_q  <= 1'b1;
      newd_q    <= 1'b0;
      tx_data_q <= '0;
      cnt_q     <= '0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      donetx_q  <= donetx;
      newd_q    <= newd_d;
      tx_data_q <= tx_data_d;
      cnt_q     <= cnt_d;
      err_to_q  <= err_to_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder with a behavioural transmitter and byte scoreboard.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int BIT   = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       newd;
  logic [7:0] tx_data;
  logic       donetx = 1'b1;
  logic [4:0] level;
  logic       busy;
  logic       err_to;

  logic       stuck = 1'b0;
  logic       tx_line = 1'b1;
  logic       err_exp = 1'b0;
  logic       to_test = 1'b0;
  logic [7:0] last_sent = 8'h00;

  int vectors = 0;
  int miscompares = 0;
  int writes = 0;
  int rises = 0;
  int sent = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .DEPTH   (16),
    .DATA_W  (8),
    .TIMEOUT (4096)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .newd     (newd),
    .tx_data  (tx_data),
    .donetx   (donetx),
    .level    (level),
    .busy     (busy),
    .err_to   (err_to)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Transmitter: accepts newd after 0..3 clk, holds donetx low for a 10-bit frame.
  initial begin : tx_model
    int phase;
    int dly;
    int cnt;
    logic [7:0] cur;
    phase = 0; dly = 0; cnt = 0; cur = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        phase = 0; donetx = 1'b1; tx_line = 1'b1;
      end else begin
        case (phase)
          0: if (newd && !stuck) begin dly = $urandom_range(0, 3); phase = 1; end
          1: begin
            if (dly == 0) begin
              cur = tx_data; donetx = 1'b0; tx_line = 1'b0; cnt = 0; phase = 2;
            end else dly--;
          end
          default: begin
            cnt++;
            if (cnt == 10 * BIT) begin
              donetx = 1'b1; tx_line = 1'b1; phase = 0; sent++; last_sent = cur;
              if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL tx_spurious: got byte %0h, expected none queued", cur);
              end else chk("tx_byte", cur, exp_q.pop_front());
            end else tx_line = frame_bit(cur, cnt / BIT);
          end
        endcase
      end
    end
  end

  // Per-cycle checks against the producer/transmitter bookkeeping.
  logic       prev_newd = 1'b0;
  logic       seen_low = 1'b0;
  logic [7:0] hold = 8'h00;
  always @(negedge clk) begin
    if (!rst) begin
      prev_newd = 1'b0;
    end else begin
      if (newd && !prev_newd) begin rises++; hold = tx_data; seen_low = 1'b0; end
      chk("in_ready", in_ready, level != 5'(DEPTH));
      chk("level_range", (int'(level) <= writes - rises) && (int'(level) >= writes - rises - 1)
                         && (int'(level) <= DEPTH), 1);
      if (level != 0 || newd || !donetx) chk("busy", busy, 1);
      if ((newd && prev_newd) || (!donetx && !newd)) chk("tx_data_stable", tx_data, hold);
      if (!newd && prev_newd) chk("newd_drop_after_ack", seen_low, 1);
      if (!donetx) seen_low = 1'b1;
      if (!to_test) chk("err_to", err_to, err_exp);
      prev_newd = newd;
    end
  end

  task automatic push(input logic [7:0] d, input int budget);
    int n;
    logic r;
    n = 0;
    in_valid = 1'b1; in_data = d;
    forever begin
      r = in_ready;
      @(posedge clk); #1;
      if (r) break;
      n++;
      if (n > budget) break;
    end
    if (r) begin exp_q.push_back(d); writes++; end
    else chk("push_accept", r, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int target, input int budget, input string name);
    int n;
    n = 0;
    while ((sent < target || busy) && n < budget) begin @(negedge clk); n++; end
    chk(name, sent, target);
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_newd"}, newd, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_err_to"}, err_to, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    logic [9:0] got;
    logic [9:0] exp_line;
    int base;
    exp_line = 10'b1101001010;
    got = '0;

    repeat (3) @(posedge clk); #1;
    chk_reset_state("reset");
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_level", level, 0); chk("idle_in_ready", in_ready, 1);
      chk("idle_newd", newd, 0);   chk("idle_busy", busy, 0);
    end

    // Single byte 0xA5: tx_data at write+2, newd at write+3, LSB-first on the line.
    @(posedge clk); #1;
    push(8'hA5, 10);
    chk("a5_newd_c1", newd, 0);
    @(posedge clk); #1;
    chk("a5_tx_data_c2", tx_data, 8'hA5); chk("a5_newd_c2", newd, 0);
    @(posedge clk); #1;
    chk("a5_newd_c3", newd, 1);
    n = 0;
    while (tx_line !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    chk("a5_line_start", tx_line, 0);
    repeat (BIT / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      got[i] = tx_line;
      if (i < 9) repeat (BIT) @(negedge clk);
    end
    chk("a5_line_bits", got, exp_line);
    wait_drain(1, 300, "a5_done");
    chk("a5_last_sent", last_sent, 8'hA5);

    // Fill to 16 with the transmitter stalled, then hold a write while full.
    stuck = 1'b1;
    for (int i = 1; i <= 17; i++) push(8'(i), 10);
    @(negedge clk);
    chk("full_level", level, 16); chk("full_in_ready", in_ready, 0);
    base = sent;
    fork
      push(8'h12, 500);
      begin
        repeat (30) begin @(negedge clk); chk("full_hold", level, 16); end
        stuck = 1'b0;
      end
    join
    chk("accept_after_pop", sent > base, 1);
    wait_drain(19, 3000, "burst_done");
    chk("burst_queue_empty", exp_q.size(), 0);

    // Stuck-high donetx: err_to after 4096 clk in REQ, request held.
    stuck = 1'b1; to_test = 1'b1;
    push(8'h77, 10);
    n = 0;
    while (!newd && n < 10) begin @(negedge clk); n++; end
    chk("to_newd_up", newd, 1);
    n = 0;
    do begin
      @(negedge clk); n++;
      chk("to_newd_held", newd, 1);
      chk("to_tx_data_held", tx_data, 8'h77);
    end while (!err_to && n < 5000);
    chk("to_cycles", n, 4096);
    err_exp = 1'b1; to_test = 1'b0; stuck = 1'b0;
    wait_drain(20, 300, "to_done");
    chk("to_sticky", err_to, 1);

    // Asynchronous reset mid-burst with five bytes queued.
    for (int i = 0; i < 8; i++) push(8'($urandom), 10);
    n = 0;
    while (level != 5 && n < 1000) begin @(negedge clk); n++; end
    chk("pre_reset_level", level, 5);
    #2; rst = 1'b0; #1;
    chk_reset_state("async_rst");
    exp_q.delete(); writes = 0; rises = 0; err_exp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    base = sent;
    @(posedge clk); #1;
    push(8'h3C, 10);
    wait_drain(base + 1, 300, "post_reset_done");
    chk("post_reset_byte", last_sent, 8'h3C);

    // Random traffic with random gaps and random ack delay.
    base = sent;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1;
      push(8'($urandom), 500);
    end
    wait_drain(base + 40, 6000, "random_done");
    chk("random_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
